// File: rtl/scroll_pkg.sv
// Shared glyph codes, controller state encoding and the power-on message
// for the scrolling 8-digit display.
package scroll_pkg;

  localparam logic [3:0] GLYPH_BLANK = 4'h0;
  localparam logic [3:0] GLYPH_H     = 4'h1;
  localparam logic [3:0] GLYPH_E     = 4'h2;
  localparam logic [3:0] GLYPH_L     = 4'h3;
  localparam logic [3:0] GLYPH_O     = 4'h4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  // Slot i lives at bits [4i+3:4i]; slot 0 is the first letter shown.
  localparam logic [31:0] DEFAULT_MSG = {GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK,
                                         GLYPH_O, GLYPH_L, GLYPH_L, GLYPH_E, GLYPH_H};

  function automatic logic [3:0] msg_slot(input logic [31:0] msg, input logic [2:0] idx);
    return msg[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/scroll_prescaler.sv
// Scroll-rate divider: emits a one-cycle tick every TICK_DIV enabled cycles.
module scroll_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  assign tick = en && (count_q == LAST);

  // next count: clear wins, otherwise count while enabled and hold when not
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tick ? '0 : count_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Scrolling message sequencer for HEX7..HEX0: message buffer, run/pause/step FSM
// and rotation mapping. Optional post-wrap blanking under HEX_SCROLL_BLINK_EN.
module hex_scroll_ctrl
  import scroll_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        run,
  input  logic        pause,
  input  logic        dir,
  input  logic        step,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [3:0]  wr_data,
  output logic        wr_ack,
  output logic [2:0]  offset,
  output logic [31:0] digit_code,
  output logic [1:0]  state,
  output logic        wrap_pulse
);

  state_t      state_q, state_d;
  logic [2:0]  offset_q, offset_d;
  logic [31:0] msg_q, msg_d;
  logic        wr_ack_q, wr_ack_d;
  logic        wrap_q, wrap_d;
  logic        tick_s, advance_s;
  logic [31:0] map_s;

  scroll_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .clr      (state_q == IDLE),
    .en       (state_q == RUN),
    .tick     (tick_s)
  );

  // next-state, advance, message write and pulse outputs
  always_comb begin
    state_d   = state_q;
    advance_s = 1'b0;
    case (state_q)
      IDLE: begin
        advance_s = step;
        state_d   = run ? RUN : IDLE;
      end
      RUN: begin
        advance_s = tick_s;
        if (!run)       state_d = IDLE;
        else if (pause) state_d = PAUSED;
        else            state_d = RUN;
      end
      PAUSED: begin
        advance_s = step;
        if (!run)       state_d = IDLE;
        else if (!pause) state_d = RUN;
        else            state_d = PAUSED;
      end
      default: begin
        advance_s = 1'b0;
        state_d   = IDLE;
      end
    endcase

    if (advance_s) begin
      offset_d = dir ? offset_q - 3'd1 : offset_q + 3'd1;
    end else begin
      offset_d = offset_q;
    end
    wrap_d = advance_s && (offset_d == 3'd0);

    msg_d = msg_q;
    if (wr_en) begin
      msg_d[{wr_addr, 2'b00} +: 4] = wr_data;
    end else begin
      msg_d = msg_q;
    end
    wr_ack_d = wr_en;
  end

  // controller registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= IDLE;
      offset_q <= 3'd0;
      msg_q    <= DEFAULT_MSG;
      wr_ack_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      msg_q    <= msg_d;
      wr_ack_q <= wr_ack_d;
      wrap_q   <= wrap_d;
    end
  end

  // digit i shows slot (offset + 7 - i) mod 8, so HEX7 leads the message
  always_comb begin
    map_s = 32'h0;
    for (int i = 0; i < 8; i++) begin
      map_s[4*i +: 4] = msg_slot(msg_q, offset_q + 3'd7 - 3'(i));
    end
  end

`ifdef HEX_SCROLL_BLINK_EN
  logic blank_q, blank_d;

  // blank window opens on a wrap, closes on the next tick or a paused step
  always_comb begin
    if (advance_s && (offset_d == 3'd0)) begin
      blank_d = 1'b1;
    end else if (tick_s || ((state_q == PAUSED) && step)) begin
      blank_d = 1'b0;
    end else begin
      blank_d = blank_q;
    end
  end

  // blank window register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      blank_q <= 1'b0;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign digit_code = blank_q ? {8{GLYPH_BLANK}} : map_s;
`else
  assign digit_code = map_s;
`endif

  assign offset     = offset_q;
  assign state      = state_q;
  assign wr_ack     = wr_ack_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Self-checking bench for hex_scroll_ctrl with TICK_DIV=4: cycle model feeding
// a scoreboard, plus scenario tasks with hand-derived checks.
module tb_hex_scroll_ctrl;

  logic        clk = 1'b0;
  logic        reset, run, pause, dir, step, wr_en;
  logic [2:0]  wr_addr;
  logic [3:0]  wr_data;
  logic        wr_ack, wrap_pulse;
  logic [2:0]  offset;
  logic [31:0] digit_code;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] RESET_DIGITS = 32'h1233_4000;

  hex_scroll_ctrl #(.TICK_DIV(4)) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .run        (run),
    .pause      (pause),
    .dir        (dir),
    .step       (step),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .offset     (offset),
    .digit_code (digit_code),
    .state      (state),
    .wrap_pulse (wrap_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  off;
    logic [1:0]  st;
    logic        wrap;
    logic        ack;
    logic [31:0] dc;
  } exp_t;

  exp_t sb_q[$];

  logic [1:0] m_st  = 2'd0;
  logic [2:0] m_off = 3'd0;
  int         m_cnt = 0;
  logic [3:0] m_msg [8];

  // reference model: predict the registered outputs after each edge
  always @(posedge clk) begin : model
    logic [3:0] nmsg [8];
    logic [1:0] nst;
    logic [2:0] noff;
    int         ncnt;
    logic       adv;
    exp_t       e;
    if (reset) begin
      nmsg = '{4'h1, 4'h2, 4'h3, 4'h3, 4'h4, 4'h0, 4'h0, 4'h0};
      nst = 2'd0; noff = 3'd0; ncnt = 0;
      e.wrap = 1'b0; e.ack = 1'b0;
    end else begin
      nmsg = m_msg;
      adv  = (m_st == 2'd1) ? (m_cnt == 3) : step;
      if (m_st == 2'd1)      ncnt = (m_cnt == 3) ? 0 : m_cnt + 1;
      else if (m_st == 2'd2) ncnt = m_cnt;
      else                   ncnt = 0;
      noff = m_off;
      if (adv) noff = dir ? m_off - 3'd1 : m_off + 3'd1;
      e.wrap = adv && (noff == 3'd0);
      e.ack  = wr_en;
      if (wr_en) nmsg[wr_addr] = wr_data;
      case (m_st)
        2'd0:    nst = run ? 2'd1 : 2'd0;
        2'd1:    nst = !run ? 2'd0 : (pause ? 2'd2 : 2'd1);
        default: nst = !run ? 2'd0 : (pause ? 2'd2 : 2'd1);
      endcase
    end
    e.off = noff;
    e.st  = nst;
    for (int i = 0; i < 8; i++) e.dc[4*i +: 4] = nmsg[(int'(noff) + 7 - i) % 8];
    sb_q.push_back(e);
    m_msg <= nmsg;
    m_st  <= nst;
    m_off <= noff;
    m_cnt <= ncnt;
  end

  // scoreboard: compare DUT outputs against the prediction for the last edge
  always @(negedge clk) begin : scoreboard
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      total++;
      if (offset !== e.off || state !== e.st || wrap_pulse !== e.wrap ||
          wr_ack !== e.ack || digit_code !== e.dc) begin
        bad++;
        $display("FAIL scoreboard t=%0t got off=%0d st=%0d wrap=%b ack=%b dc=%h want off=%0d st=%0d wrap=%b ack=%b dc=%h",
                 $time, offset, state, wrap_pulse, wr_ack, digit_code,
                 e.off, e.st, e.wrap, e.ack, e.dc);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; pause = 1'b0; step = 1'b0; wr_en = 1'b0;
    cyc(1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; pause = 1'b0; dir = 1'b0; step = 1'b0;
    wr_en = 1'b0; wr_addr = 3'd0; wr_data = 4'd0;
    cyc(2);
    total++;
    if (offset !== 3'd0 || state !== 2'd0 || wrap_pulse !== 1'b0 || wr_ack !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got off=%0d st=%0d wrap=%b ack=%b want 0 0 0 0",
               offset, state, wrap_pulse, wr_ack);
    end
    total++;
    if (digit_code !== RESET_DIGITS) begin
      bad++;
      $display("FAIL reset_digits got %h want %h", digit_code, RESET_DIGITS);
    end
  endtask

  task automatic test_run();
    reset = 1'b0; run = 1'b1;
    cyc(5);
    total++;
    if (offset !== 3'd1 || digit_code[31:28] !== 4'h2) begin
      bad++;
      $display("FAIL run_first_step got off=%0d hex7=%h want 1 2", offset, digit_code[31:28]);
    end
    cyc(3);
    total++;
    if (offset !== 3'd1) begin
      bad++;
      $display("FAIL run_hold got off=%0d want 1", offset);
    end
    cyc(1);
    total++;
    if (offset !== 3'd2) begin
      bad++;
      $display("FAIL run_second_step got off=%0d want 2", offset);
    end
    cyc(4);
    total++;
    if (offset !== 3'd3) begin
      bad++;
      $display("FAIL run_third_step got off=%0d want 3", offset);
    end
  endtask

  task automatic test_wrap();
    int wraps = 0;
    bit seen  = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cyc(1);
      if (wrap_pulse === 1'b1) wraps++;
      if (offset === 3'd0 && !seen) begin
        seen = 1'b1;
        total++;
        if (digit_code !== RESET_DIGITS || wrap_pulse !== 1'b1) begin
          bad++;
          $display("FAIL wrap_digits got dc=%h wrap=%b want %h 1", digit_code, wrap_pulse, RESET_DIGITS);
        end
      end
    end
    total++;
    if (!seen || wraps != 1) begin
      bad++;
      $display("FAIL wrap_count got seen=%0d pulses=%0d want 1 1", seen, wraps);
    end
  endtask

  task automatic test_pause();
    do_reset();
    run = 1'b1; pause = 1'b0;
    cyc(3);
    pause = 1'b1;
    cyc(10);
    total++;
    if (offset !== 3'd0 || state !== 2'd2) begin
      bad++;
      $display("FAIL pause_frozen got off=%0d st=%0d want 0 2", offset, state);
    end
    pause = 1'b0;
    cyc(1);
    total++;
    if (offset !== 3'd0 || state !== 2'd1) begin
      bad++;
      $display("FAIL pause_release got off=%0d st=%0d want 0 1", offset, state);
    end
    cyc(1);
    total++;
    if (offset !== 3'd1) begin
      bad++;
      $display("FAIL pause_next_tick got off=%0d want 1", offset);
    end
  endtask

  task automatic step_once(input logic d);
    dir = d; step = 1'b1;
    cyc(1);
    step = 1'b0;
  endtask

  task automatic test_step();
    do_reset();
    step_once(1'b1);
    total++;
    if (offset !== 3'd7 || wrap_pulse !== 1'b0) begin
      bad++;
      $display("FAIL step_down got off=%0d wrap=%b want 7 0", offset, wrap_pulse);
    end
    step_once(1'b1);
    total++;
    if (offset !== 3'd6) begin
      bad++;
      $display("FAIL step_down2 got off=%0d want 6", offset);
    end
    step_once(1'b0);
    step_once(1'b0);
    total++;
    if (offset !== 3'd0 || wrap_pulse !== 1'b1) begin
      bad++;
      $display("FAIL step_wrap_up got off=%0d wrap=%b want 0 1", offset, wrap_pulse);
    end
    step_once(1'b0);
    step_once(1'b1);
    total++;
    if (offset !== 3'd0 || wrap_pulse !== 1'b1) begin
      bad++;
      $display("FAIL step_wrap_down got off=%0d wrap=%b want 0 1", offset, wrap_pulse);
    end
    run = 1'b1; dir = 1'b0;
    cyc(1);
    step_once(1'b0);
    total++;
    if (offset !== 3'd0 || state !== 2'd1) begin
      bad++;
      $display("FAIL step_in_run got off=%0d st=%0d want 0 1", offset, state);
    end
  endtask

  task automatic test_write_tick();
    logic [2:0] pre, pos;
    bit found = 1'b0;
    dir = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      if (m_st == 2'd1 && m_cnt == 3) found = 1'b1;
      else cyc(1);
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL write_tick_wait got no tick within 8 cycles want tick");
    end
    pre = offset;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'h4;
    cyc(1);
    wr_en = 1'b0;
    pos = pre + 3'd1 + 3'd7;
    total++;
    if (offset !== pre + 3'd1 || digit_code[4*pos +: 4] !== 4'h4 || wr_ack !== 1'b1) begin
      bad++;
      $display("FAIL write_with_tick got off=%0d glyph=%h ack=%b want %0d 4 1",
               offset, digit_code[4*pos +: 4], wr_ack, pre + 3'd1);
    end
    cyc(1);
    total++;
    if (wr_ack !== 1'b0) begin
      bad++;
      $display("FAIL write_ack_drop got %b want 0", wr_ack);
    end
  endtask

  task automatic test_fsm();
    do_reset();
    run = 1'b1; pause = 1'b1;
    cyc(1);
    total++;
    if (state !== 2'd1) begin
      bad++;
      $display("FAIL fsm_idle_run got %0d want 1", state);
    end
    cyc(1);
    total++;
    if (state !== 2'd2) begin
      bad++;
      $display("FAIL fsm_run_paused got %0d want 2", state);
    end
    run = 1'b0;
    cyc(1);
    total++;
    if (state !== 2'd0) begin
      bad++;
      $display("FAIL fsm_paused_idle got %0d want 0", state);
    end
    run = 1'b1; pause = 1'b0;
    cyc(10);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'h4;
    cyc(1);
    wr_en = 1'b0;
    total++;
    if (offset !== 3'd2) begin
      bad++;
      $display("FAIL fsm_mid_scroll got off=%0d want 2", offset);
    end
    reset = 1'b1;
    cyc(1);
    reset = 1'b0; run = 1'b0;
    total++;
    if (offset !== 3'd0 || state !== 2'd0 || digit_code !== RESET_DIGITS) begin
      bad++;
      $display("FAIL fsm_mid_reset got off=%0d st=%0d dc=%h want 0 0 %h",
               offset, state, digit_code, RESET_DIGITS);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_wrap();
    test_pause();
    test_step();
    test_write_tick();
    test_fsm();
    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
